xpt_itable_sequencer: RTL

Step sequencer that owns the instruction-phase state consumed by the per-instruction decoders (the 4-bit step counter XPT, the 8-bit instruction table register ITABLE, and the cycle-mode flags) and drives the decoders' `enable`. It sits directly upstream of every `DECODER_I_*` block. Its outputs feed those decoders, and it closes the loop by registering the decoders' step-control strobes (`PR_Reset_XPT`, `P2_Set_CM1`, `P2_Set_CMR`, `P2_Reset_ITABLE`, `Pa_Ophd`). Wait states from memory stall the whole sequence.

---
 rtl/xpt_itable_sequencer_if.sv | 36 +++
 rtl/xpt_itable_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/xpt_itable_sequencer_if.sv
// Decoder-side bus of the instruction step sequencer: memory handshake, opcode byte,
// decoder step-control strobes in; step counter, instruction table, cycle mode out.
interface xpt_itable_sequencer_if;
  logic       mem_ready;
  logic [7:0] Din;
  logic       PR_Reset_XPT;
  logic       P2_Set_CM1;
  logic       P2_Set_CMR;
  logic       P2_Set_CMW;
  logic       P2_Reset_ITABLE;
  logic       Pa_Ophd;
  logic [3:0] XPT;
  logic [3:0] notXPT;
  logic [7:0] ITABLE;
  logic [7:0] notITABLE;
  logic       CM1;
  logic       CMR;
  logic       CMW;
  logic       enable;
  logic       xpt_ovf;
  logic [7:0] op_count;

  // Decoder / memory side
  modport master (
    output mem_ready, Din, PR_Reset_XPT, P2_Set_CM1, P2_Set_CMR, P2_Set_CMW,
           P2_Reset_ITABLE, Pa_Ophd,
    input  XPT, notXPT, ITABLE, notITABLE, CM1, CMR, CMW, enable, xpt_ovf, op_count
  );

  // Sequencer side
  modport slave (
    input  mem_ready, Din, PR_Reset_XPT, P2_Set_CM1, P2_Set_CMR, P2_Set_CMW,
           P2_Reset_ITABLE, Pa_Ophd,
    output XPT, notXPT, ITABLE, notITABLE, CM1, CMR, CMW, enable, xpt_ovf, op_count
  );
endinterface

// File: rtl/xpt_itable_sequencer.sv
// Instruction step sequencer: owns XPT, ITABLE and the one-hot cycle mode, advances
// them on step cycles (run & mem_ready) using the decoders' registered strobes.
module xpt_itable_sequencer (
  input  logic                         clk,
  input  logic                         notReset,
  xpt_itable_sequencer_if.slave        bus
);

  localparam int unsigned XPT_W = 4;
  localparam int unsigned TBL_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [XPT_W-1:0] XPT_MAX = {XPT_W{1'b1}};
  localparam logic [XPT_W-1:0] XPT_OPC = XPT_W'(1);

  typedef enum logic [2:0] {
    MODE_M1 = 3'b001,
    MODE_MR = 3'b010,
    MODE_MW = 3'b100
  } mode_e;

  logic             run_q;
  logic [XPT_W-1:0] xpt_q,    xpt_d;
  logic [XPT_W-1:0] nxpt_q;
  logic [TBL_W-1:0] itable_q, itable_d;
  logic [TBL_W-1:0] nitable_q;
  mode_e            mode_q,   mode_d;
  logic             ovf_q,    ovf_d;
  logic [CNT_W-1:0] opc_q,    opc_d;
  logic             step;

  assign step = run_q & bus.mem_ready;

  // Next-state for a step cycle; everything holds otherwise
  always_comb begin
    xpt_d    = xpt_q;
    itable_d = itable_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    opc_d    = opc_q;
    if (step) begin
      if (bus.PR_Reset_XPT)       xpt_d = '0;
      else if (xpt_q == XPT_MAX)  ovf_d = 1'b1;
      else                        xpt_d = xpt_q + XPT_W'(1);

      if (bus.P2_Reset_ITABLE)                            itable_d = '0;
      else if ((mode_q == MODE_M1) && (xpt_q == XPT_OPC)) itable_d = bus.Din;

      if (bus.P2_Set_CM1)      mode_d = MODE_M1;
      else if (bus.P2_Set_CMR) mode_d = MODE_MR;
      else if (bus.P2_Set_CMW) mode_d = MODE_MW;

      if (bus.Pa_Ophd) opc_d = opc_q + CNT_W'(1);
    end
  end

  // Complements are loaded from the same next-state so they never disagree
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      run_q     <= 1'b0;
      xpt_q     <= '0;
      nxpt_q    <= '1;
      itable_q  <= '0;
      nitable_q <= '1;
      mode_q    <= MODE_M1;
      ovf_q     <= 1'b0;
      opc_q     <= '0;
    end else begin
      run_q     <= 1'b1;
      xpt_q     <= xpt_d;
      nxpt_q    <= ~xpt_d;
      itable_q  <= itable_d;
      nitable_q <= ~itable_d;
      mode_q    <= mode_d;
      ovf_q     <= ovf_d;
      opc_q     <= opc_d;
    end
  end

  assign bus.XPT       = xpt_q;
  assign bus.notXPT    = nxpt_q;
  assign bus.ITABLE    = itable_q;
  assign bus.notITABLE = nitable_q;
  assign bus.CM1       = mode_q[0];
  assign bus.CMR       = mode_q[1];
  assign bus.CMW       = mode_q[2];
  assign bus.enable    = step;
  assign bus.xpt_ovf   = ovf_q;
  assign bus.op_count  = opc_q;

endmodule
